// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words through a req/ack memory port into a small FIFO,
// delivers them with valid/ready, and supports redirect/flush and a halt opcode.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2,
  parameter logic [4:0]        HALT_OP  = 5'b11111
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ir_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              halted
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALTED} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, mem_addr_q, mem_addr_d, pc_out_q, pc_out_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [31:0]       ir_out_q, ir_out_d;
  logic              mem_req_q, mem_req_d, ir_valid_q, ir_valid_d, halted_q, halted_d;
  logic              push, pop, room, is_halt;
  logic [31:0]       ir_buf_q [DEPTH];
  logic [ADDR_W-1:0] pc_buf_q [DEPTH];
  // redirect voids both the push of acked data and any pop in the same cycle
  always_comb begin
    push       = state_q == REQ && mem_ack && !redirect;
    pop        = ir_valid_q && ir_ready && !redirect;
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d       = redirect ? '0 : rd_q + PW'(pop);
    wr_d       = redirect ? '0 : wr_q + PW'(push);
    fetch_pc_d = redirect ? redirect_pc : fetch_pc_q + ADDR_W'(push);
    is_halt    = mem_rdata[31:27] == HALT_OP;
    room       = en && count_d < CW'(DEPTH);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = room ? REQ : IDLE;
      REQ:     state_d = redirect ? (mem_ack ? IDLE : DISCARD) :
                         !mem_ack ? REQ : is_halt ? HALTED : room ? REQ : IDLE;
      DISCARD: state_d = !mem_ack ? DISCARD : en ? REQ : IDLE;
      HALTED:  state_d = redirect ? IDLE : HALTED;
      default: state_d = IDLE;
    endcase
  end
  // a pending request keeps its original address until acked, even across a redirect
  always_comb begin
    mem_req_d  = state_d == REQ || state_d == DISCARD;
    mem_addr_d = state_d == DISCARD ? mem_addr_q : fetch_pc_d;
    ir_valid_d = count_d != '0;
    halted_d   = state_d == HALTED;
    ir_out_d   = count_d == '0 ? ir_out_q : (push && wr_q == rd_d) ? mem_rdata : ir_buf_q[rd_d];
    pc_out_d   = count_d == '0 ? pc_out_q : (push && wr_q == rd_d) ? fetch_pc_q : pc_buf_q[rd_d];
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      ir_out_q   <= '0;
      pc_out_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_req_q  <= mem_req_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      ir_out_q   <= ir_out_d;
      pc_out_q   <= pc_out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ir_buf_q[wr_q] <= mem_rdata;
      pc_buf_q[wr_q] <= fetch_pc_q;
    end
  end
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;
  assign ir_out   = ir_out_q;
  assign pc_out   = pc_out_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios against a behavioural memory with
// selectable fixed latency or manually driven acknowledge.
module tb_instr_fetch_unit;
  logic        clk = 0, clr = 1, en = 0, redirect = 0, ir_ready = 0, auto = 1, man_ack = 0;
  logic        mem_ack, mem_req, ir_valid, halted;
  logic [8:0]  mem_addr, pc_out, redirect_pc = '0;
  logic [31:0] mem_rdata, ir_out;
  logic [31:0] mem [512];
  int          lat = 0, wait_cnt = 0, total = 0, bad = 0;

  instr_fetch_unit dut (
    .clk(clk), .clr(clr), .en(en), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_out(ir_out), .pc_out(pc_out), .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = auto ? (mem_req && wait_cnt == lat) : man_ack;
  always @(posedge clk) wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;

  task automatic test_reset();
    clr = 1; en = 0; ir_ready = 0; redirect = 0; man_ack = 0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid got=%b want=0", ir_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
    total++; if (mem_addr !== 9'h000) begin bad++; $display("FAIL rst_mem_addr got=%h want=000", mem_addr); end
    total++; if (ir_out !== 32'h0) begin bad++; $display("FAIL rst_ir_out got=%h want=0", ir_out); end
    total++; if (pc_out !== 9'h000) begin bad++; $display("FAIL rst_pc_out got=%h want=000", pc_out); end
    repeat (2) @(negedge clk);
    clr = 0;
  endtask

  task automatic test_stream();
    logic [31:0] exp_ir [4];
    exp_ir[0] = 32'h08800001; exp_ir[1] = 32'h09000002; exp_ir[2] = 32'h09800003; exp_ir[3] = 32'hF8000000;
    auto = 1; lat = 0;
    test_reset();
    en = 1; ir_ready = 1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || ir_valid !== 1'b0) begin bad++; $display("FAIL stream_edge1 got req=%b valid=%b want req=1 valid=0", mem_req, ir_valid); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (ir_valid !== 1'b1 || pc_out !== 9'(i) || ir_out !== exp_ir[i])
        begin bad++; $display("FAIL stream_word%0d got valid=%b pc=%h ir=%h want valid=1 pc=%h ir=%h", i, ir_valid, pc_out, ir_out, 9'(i), exp_ir[i]); end
    end
    total++; if (halted !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL stream_halt got halted=%b req=%b want halted=1 req=0", halted, mem_req); end
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b0 || halted !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL stream_drained got valid=%b halted=%b req=%b want 0 1 0", ir_valid, halted, mem_req); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    auto = 1; lat = 3;
    test_reset();
    en = 1; ir_ready = 0;
    repeat (15) begin @(negedge clk); if (mem_ack) n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL bp_acks got=%0d want=2", n); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_idle got=%b want=0", mem_req); end
    total++; if (ir_valid !== 1'b1 || ir_out !== 32'h08800001 || pc_out !== 9'h000) begin bad++; $display("FAIL bp_hold got valid=%b ir=%h pc=%h want 1 08800001 000", ir_valid, ir_out, pc_out); end
    ir_ready = 1;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h002) begin bad++; $display("FAIL bp_resume got req=%b addr=%h want 1 002", mem_req, mem_addr); end
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h001 || ir_out !== 32'h09000002) begin bad++; $display("FAIL bp_pop got valid=%b pc=%h ir=%h want 1 001 09000002", ir_valid, pc_out, ir_out); end
  endtask

  task automatic test_redirect_discard();
    auto = 0; man_ack = 0;
    test_reset();
    en = 1; redirect = 1; redirect_pc = 9'h004;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h004) begin bad++; $display("FAIL disc_start got req=%b addr=%h want 1 004", mem_req, mem_addr); end
    @(negedge clk); redirect = 0; man_ack = 1;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h004 || mem_addr !== 9'h005) begin bad++; $display("FAIL disc_word4 got valid=%b pc=%h addr=%h want 1 004 005", ir_valid, pc_out, mem_addr); end
    @(negedge clk); man_ack = 0; redirect = 1; redirect_pc = 9'h040;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 9'h005) begin bad++; $display("FAIL disc_enter got valid=%b req=%b addr=%h want 0 1 005", ir_valid, mem_req, mem_addr); end
    @(negedge clk); redirect = 0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h005) begin bad++; $display("FAIL disc_hold got req=%b addr=%h want 1 005", mem_req, mem_addr); end
    @(negedge clk); man_ack = 1;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 9'h040) begin bad++; $display("FAIL disc_drop got valid=%b req=%b addr=%h want 0 1 040", ir_valid, mem_req, mem_addr); end
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h040 || ir_out !== 32'h00100040) begin bad++; $display("FAIL disc_new got valid=%b pc=%h ir=%h want 1 040 00100040", ir_valid, pc_out, ir_out); end
    @(negedge clk); man_ack = 0;
  endtask

  task automatic test_redirect_ack();
    auto = 0; man_ack = 0;
    test_reset();
    en = 1; redirect = 1; redirect_pc = 9'h006;
    @(posedge clk);
    @(negedge clk); redirect = 0; man_ack = 1;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h006 || mem_addr !== 9'h007) begin bad++; $display("FAIL rack_word6 got valid=%b pc=%h addr=%h want 1 006 007", ir_valid, pc_out, mem_addr); end
    @(negedge clk); redirect = 1; redirect_pc = 9'h0A0;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rack_flush got valid=%b req=%b want 0 0", ir_valid, mem_req); end
    @(negedge clk); redirect = 0; man_ack = 0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h0A0) begin bad++; $display("FAIL rack_next got req=%b addr=%h want 1 0a0", mem_req, mem_addr); end
    @(negedge clk); man_ack = 1;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h0A0 || ir_out !== 32'h001000A0) begin bad++; $display("FAIL rack_new got valid=%b pc=%h ir=%h want 1 0a0 001000a0", ir_valid, pc_out, ir_out); end
    @(negedge clk); man_ack = 0;
  endtask

  task automatic test_wrap();
    auto = 1; lat = 0;
    test_reset();
    en = 1; ir_ready = 1; redirect = 1; redirect_pc = 9'h1FF;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h1FF) begin bad++; $display("FAIL wrap_req got req=%b addr=%h want 1 1ff", mem_req, mem_addr); end
    @(negedge clk); redirect = 0;
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h1FF || mem_addr !== 9'h000) begin bad++; $display("FAIL wrap_first got valid=%b pc=%h addr=%h want 1 1ff 000", ir_valid, pc_out, mem_addr); end
    @(posedge clk); #1;
    total++; if (pc_out !== 9'h000 || ir_out !== 32'h08800001 || mem_addr !== 9'h001) begin bad++; $display("FAIL wrap_second got pc=%h ir=%h addr=%h want 000 08800001 001", pc_out, ir_out, mem_addr); end
  endtask

  task automatic test_async_reset();
    auto = 1; lat = 3;
    test_reset();
    en = 1; ir_ready = 0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (ir_valid !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 9'h001) begin bad++; $display("FAIL ar_pre got valid=%b req=%b addr=%h want 1 1 001", ir_valid, mem_req, mem_addr); end
    #2 clr = 1;
    #1;
    total++; if (ir_valid !== 1'b0 || mem_req !== 1'b0 || halted !== 1'b0 || mem_addr !== 9'h000) begin bad++; $display("FAIL ar_async got valid=%b req=%b halted=%b addr=%h want 0 0 0 000", ir_valid, mem_req, halted, mem_addr); end
    @(negedge clk); clr = 0; lat = 0;
    @(posedge clk); #1;
    total++; if (mem_req !== 1'b1 || mem_addr !== 9'h000) begin bad++; $display("FAIL ar_restart got req=%b addr=%h want 1 000", mem_req, mem_addr); end
    @(posedge clk); #1;
    total++; if (ir_valid !== 1'b1 || pc_out !== 9'h000 || ir_out !== 32'h08800001) begin bad++; $display("FAIL ar_first got valid=%b pc=%h ir=%h want 1 000 08800001", ir_valid, pc_out, ir_out); end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) mem[a] = 32'h00100000 | 32'(a);
    mem[0] = 32'h08800001; mem[1] = 32'h09000002; mem[2] = 32'h09800003; mem[3] = 32'hF8000000;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_discard();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
